// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit and receive controllers.
// Holds the state encoding, the default frame width and the serial clock ratio.
package ssp_pkg;

  localparam int SSP_WORD_BITS = 8;
  localparam int SSP_CLK_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DATA  = 2'd2
  } ssp_state_e;

endpackage

// File: rtl/ssp_clk_div.sv
// Serial clock divider shared by the SSP transmit and receive sides.
// clk_q toggles every PCLK; tick marks the PCLK edges on which clk_q rises.
module ssp_clk_div (
  input  logic PCLK,
  input  logic CLEAR_B,
  output logic clk_q,
  output logic tick
);

  // divide-by-two toggle, parked low while in reset
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      clk_q <= 1'b0;
    end else begin
      clk_q <= ~clk_q;
    end
  end

  assign tick = ~clk_q;

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops words from the TX FIFO and shifts them out MSB-first,
// each frame preceded by one serial-clock period of frame sync.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int WORD_BITS = SSP_WORD_BITS
) (
  input  logic                 PCLK,
  input  logic                 CLEAR_B,
  input  logic                 ValidWord,
  input  logic [WORD_BITS-1:0] TxData,
  output logic                 NextWord,
  output logic                 SSPCLKOUT,
  output logic                 SSPFSSOUT,
  output logic                 SSPTXD,
  output logic                 SSPOE_B,
  output logic                 SSPBUSY
);

  localparam int CNT_W = $clog2(WORD_BITS);

  logic                 clk_q_s;
  logic                 tick_s;
  ssp_state_e           state_r;
  logic [WORD_BITS-1:0] shift_r;
  logic [CNT_W-1:0]     bitcnt_r;
  logic                 next_word_r;
  logic                 fss_r;
  logic                 txd_r;
  logic                 oe_b_r;
  logic                 busy_r;

  ssp_clk_div u_clk_div (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .clk_q   (clk_q_s),
    .tick    (tick_s)
  );

  // frame sequencer; everything except the pop strobe moves only on ticks
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      state_r     <= IDLE;
      shift_r     <= {WORD_BITS{1'b0}};
      bitcnt_r    <= {CNT_W{1'b0}};
      next_word_r <= 1'b0;
      fss_r       <= 1'b0;
      txd_r       <= 1'b0;
      oe_b_r      <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      next_word_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          IDLE: begin
            if (ValidWord) begin
              shift_r     <= TxData;
              next_word_r <= 1'b1;
              fss_r       <= 1'b1;
              busy_r      <= 1'b1;
              state_r     <= FRAME;
            end else begin
              state_r     <= IDLE;
            end
          end
          FRAME: begin
            fss_r    <= 1'b0;
            txd_r    <= shift_r[WORD_BITS-1];
            oe_b_r   <= 1'b0;
            bitcnt_r <= CNT_W'(WORD_BITS - 1);
            state_r  <= DATA;
          end
          DATA: begin
            if (bitcnt_r != {CNT_W{1'b0}}) begin
              shift_r  <= {shift_r[WORD_BITS-2:0], 1'b0};
              txd_r    <= shift_r[WORD_BITS-2];
              bitcnt_r <= bitcnt_r - CNT_W'(1);
            end else begin
              // LSB period done: release the pad, then chain or go idle
              oe_b_r <= 1'b1;
              txd_r  <= 1'b0;
              if (ValidWord) begin
                shift_r     <= TxData;
                next_word_r <= 1'b1;
                fss_r       <= 1'b1;
                state_r     <= FRAME;
              end else begin
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            end
          end
          default: begin
            fss_r   <= 1'b0;
            txd_r   <= 1'b0;
            oe_b_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign NextWord  = next_word_r;
  assign SSPCLKOUT = clk_q_s;
  assign SSPFSSOUT = fss_r;
  assign SSPTXD    = txd_r;
  assign SSPOE_B   = oe_b_r;
  assign SSPBUSY   = busy_r;

endmodule
